// File: rtl/meow_recorder.sv
// Purpose : PDM microphone capture. Generates the mic clock, synchronises the 1-bit
//           stream, decimates it by counting ones per window and stores 16-bit samples in RAM.
// Latency : a sample is written on the mic tick that carries the last bit of its window; read port 1 cycle.
// Ports   : clk_in/rst_in (sync, active-high); record_in/stop_in control; mic_data_in/mic_clk_out to mic;
//           busy_out/done_out/sample_count_out status; rd_addr_in/rd_data_out sample readback.
module meow_recorder #(
    parameter int MIC_DIV   = 32,
    parameter int DECIM     = 256,
    parameter int N_SAMPLES = 7391
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             record_in,
    input  logic                             stop_in,
    input  logic                             mic_data_in,
    output logic                             mic_clk_out,
    output logic                             busy_out,
    output logic                             done_out,
    output logic [$clog2(N_SAMPLES+1)-1:0]   sample_count_out,
    input  logic [$clog2(N_SAMPLES)-1:0]     rd_addr_in,
    output logic [15:0]                      rd_data_out
);

    localparam int DIV_W  = $clog2(MIC_DIV);
    localparam int ONES_W = $clog2(DECIM) + 1;
    localparam int CNT_W  = $clog2(N_SAMPLES + 1);
    localparam int ADDR_W = $clog2(N_SAMPLES);
    // ones * (65536/DECIM) is a left shift because DECIM is a power of two
    localparam int SHIFT  = 16 - $clog2(DECIM);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Mic clock divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             mic_clk_q, mic_clk_d;
    logic             mic_tick;

    assign mic_tick  = (div_cnt_q == DIV_W'(MIC_DIV - 1));
    assign div_cnt_d = mic_tick ? '0 : div_cnt_q + DIV_W'(1);
    // Computed from the next count so the registered clock always matches
    // the current div_cnt_q: high for the first half of the period.
    assign mic_clk_d = (div_cnt_d < DIV_W'(MIC_DIV / 2));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt_q <= '0;
            mic_clk_q <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign mic_clk_out = mic_clk_q;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous PDM bit
    // ------------------------------------------------------------------
    logic [1:0] mic_sync_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mic_sync_q <= '0;
        end else begin
            mic_sync_q <= {mic_sync_q[0], mic_data_in};
        end
    end

    // ------------------------------------------------------------------
    // Decimation arithmetic
    // ------------------------------------------------------------------
    logic [ONES_W-1:0] ones_acc_q;
    logic [ONES_W-1:0] bit_cnt_q;
    logic [ONES_W-1:0] ones_sum;
    logic [16:0]       scaled;
    logic [15:0]       sample_d;
    logic              window_full;

    // The bit sampled on this tick is folded in before scaling so the final
    // bit of the window is part of the written sample.
    assign ones_sum    = ones_acc_q + ONES_W'(mic_sync_q[1]);
    assign scaled      = 17'(ones_sum) << SHIFT;
    // Only an all-ones window reaches 65536; clamp it to full scale.
    assign sample_d    = scaled[16] ? 16'hFFFF : scaled[15:0];
    assign window_full = (bit_cnt_q == ONES_W'(DECIM - 1));

    // ------------------------------------------------------------------
    // Recording FSM with registered status outputs
    // ------------------------------------------------------------------
    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [CNT_W-1:0]  sample_count_q;
    logic              wr_en;
    logic              last_write;

    // stop_in wins over a write landing on the same cycle, so the partial
    // (or just-completed) window is dropped.
    assign wr_en      = (state_q == S_RECORD) && !stop_in && mic_tick && window_full;
    assign last_write = (sample_count_q == CNT_W'(N_SAMPLES - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            ones_acc_q     <= '0;
            bit_cnt_q      <= '0;
            wr_addr_q      <= '0;
            sample_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (record_in) begin
                        state_q        <= S_RECORD;
                        busy_q         <= 1'b1;
                        ones_acc_q     <= '0;
                        bit_cnt_q      <= '0;
                        wr_addr_q      <= '0;
                        sample_count_q <= '0;
                    end
                end
                S_RECORD: begin
                    if (stop_in) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (mic_tick) begin
                        if (window_full) begin
                            ones_acc_q     <= '0;
                            bit_cnt_q      <= '0;
                            wr_addr_q      <= wr_addr_q + ADDR_W'(1);
                            sample_count_q <= sample_count_q + CNT_W'(1);
                            if (last_write) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            ones_acc_q <= ones_sum;
                            bit_cnt_q  <= bit_cnt_q + ONES_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Single-cycle completion pulse; record_in is not looked at here.
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_out         = busy_q;
    assign done_out         = done_q;
    assign sample_count_out = sample_count_q;

    // ------------------------------------------------------------------
    // Sample RAM: one write port from the FSM, one always-on read port.
    // Not reset; read-first on an address collision.
    // ------------------------------------------------------------------
    logic [15:0] mem_q [N_SAMPLES];
    logic [15:0] rd_data_q;

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_q[wr_addr_q] <= sample_d;
        end
        rd_data_q <= mem_q[rd_addr_in];
    end

    assign rd_data_out = rd_data_q;

endmodule

// File: tb/tb_meow_recorder.sv
// Purpose : self-checking bench for meow_recorder with a small behavioural model.
// Latency : model predicts post-edge outputs every cycle; read data 1 cycle after address.
// Ports   : drives all DUT inputs on the falling edge, compares 1 time unit after the rising edge.
module tb_meow_recorder;

    localparam int MIC_DIV   = 4;
    localparam int DECIM     = 8;
    localparam int N_SAMPLES = 4;
    localparam int CNT_W     = $clog2(N_SAMPLES + 1);
    localparam int ADDR_W    = $clog2(N_SAMPLES);

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              record_in;
    logic              stop_in;
    logic              mic_data_in;
    logic              mic_clk_out;
    logic              busy_out;
    logic              done_out;
    logic [CNT_W-1:0]  sample_count_out;
    logic [ADDR_W-1:0] rd_addr_in;
    logic [15:0]       rd_data_out;

    always #5 clk_in = ~clk_in;

    meow_recorder #(
        .MIC_DIV   (MIC_DIV),
        .DECIM     (DECIM),
        .N_SAMPLES (N_SAMPLES)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .record_in        (record_in),
        .stop_in          (stop_in),
        .mic_data_in      (mic_data_in),
        .mic_clk_out      (mic_clk_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .sample_count_out (sample_count_out),
        .rd_addr_in       (rd_addr_in),
        .rd_data_out      (rd_data_out)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: position in the mic period, phase (0 idle,
    // 1 recording, 2 done), list of bits gathered for the current window,
    // and an image of the sample RAM.
    // ------------------------------------------------------------------
    int m_cyc = 0;
    int m_phase = 0;
    int m_cnt = 0;
    int m_hist[$] = '{0, 0};
    int m_bits[$];
    int m_mem[N_SAMPLES];
    bit m_known[N_SAMPLES];
    int exp_rd = 0;
    bit exp_rd_known = 0;
    bit tick_v;
    int bit_v;
    int ones_v;
    int samp_v;

    always begin
        @(posedge clk_in);
        exp_rd_known = m_known[rd_addr_in];
        exp_rd       = m_mem[rd_addr_in];
        if (rst_in) begin
            m_cyc   = 0;
            m_phase = 0;
            m_cnt   = 0;
            m_bits.delete();
            m_hist.push_back(0);
        end else begin
            tick_v = (m_cyc == MIC_DIV - 1);
            // The synchronised bit visible now was presented two edges ago.
            bit_v  = m_hist[m_hist.size() - 2];
            m_hist.push_back(int'(mic_data_in));
            if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (record_in) begin
                    m_phase = 1;
                    m_cnt   = 0;
                    m_bits.delete();
                end
            end else begin
                if (stop_in) begin
                    m_phase = 2;
                end else if (tick_v) begin
                    m_bits.push_back(bit_v);
                    if (m_bits.size() == DECIM) begin
                        ones_v = m_bits.sum();
                        samp_v = ones_v * (65536 / DECIM);
                        if (samp_v > 65535) samp_v = 65535;
                        m_mem[m_cnt]   = samp_v;
                        m_known[m_cnt] = 1'b1;
                        m_cnt++;
                        m_bits.delete();
                        if (m_cnt == N_SAMPLES) m_phase = 2;
                    end
                end
            end
            m_cyc = (m_cyc + 1) % MIC_DIV;
        end
        while (m_hist.size() > 4) void'(m_hist.pop_front());
        #1;
        chk("mic_clk", 32'(mic_clk_out), 32'(m_cyc < MIC_DIV / 2));
        chk("busy", 32'(busy_out), 32'(m_phase == 1));
        chk("done", 32'(done_out), 32'(m_phase == 2));
        chk("sample_count", 32'(sample_count_out), 32'(m_cnt));
        if (exp_rd_known) chk("rd_data", 32'(rd_data_out), 32'(exp_rd));
        if (done_out) done_seen++;
    end

    // Optional square wave on mic_data_in, toggling once per mic period.
    bit alt_en = 0;
    int neg_cnt = 0;
    always @(negedge clk_in) begin
        neg_cnt++;
        if (alt_en && (neg_cnt % MIC_DIV == 0)) mic_data_in = ~mic_data_in;
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Start a recording and wait (bounded) for its done pulse.
    task automatic record_wait(input string name, input int pulse_at, output int lat);
        int d;
        record_in = 1'b1;
        cyc_n(1);
        record_in = 1'b0;
        d   = done_seen;
        lat = 1;
        while (done_seen == d && lat < 400) begin
            if (lat == pulse_at) record_in = 1'b1;
            else record_in = 1'b0;
            cyc_n(1);
            lat++;
        end
        record_in = 1'b0;
        chk({name, "_done_timeout"}, 32'(done_seen == d), 32'd0);
    endtask

    task automatic rd_chk(input string name, input int addr, input logic [15:0] exp);
        @(negedge clk_in);
        rd_addr_in = ADDR_W'(addr);
        @(posedge clk_in);
        #2;
        chk(name, 32'(rd_data_out), 32'(exp));
    endtask

    int lat;
    int d0;
    int hi;

    initial begin
        rst_in      = 1'b1;
        record_in   = 1'b0;
        stop_in     = 1'b0;
        mic_data_in = 1'b0;
        rd_addr_in  = '0;
        cyc_n(3);
        rst_in = 1'b0;

        // Idle: no done pulses, mic clock half-high duty.
        d0 = done_seen;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_n(1);
            if (mic_clk_out) hi++;
        end
        chk("idle_no_done", 32'(done_seen - d0), 32'd0);
        chk("idle_mic_clk_high_cycles", 32'(hi), 32'd10);
        chk("idle_busy", 32'(busy_out), 32'd0);

        // All ones: full-scale samples, roughly 128 cycles to finish.
        mic_data_in = 1'b1;
        cyc_n(4);
        record_wait("ones", -1, lat);
        chk("ones_latency_window", 32'(lat >= 124 && lat <= 136), 32'd1);
        chk("ones_count", 32'(sample_count_out), 32'd4);
        cyc_n(1);
        chk("ones_done_one_cycle", 32'(done_out), 32'd0);
        for (int a = 0; a < 4; a++) rd_chk("ones_ram", a, 16'hFFFF);

        // All zeros, with a record pulse mid-way that must not restart.
        mic_data_in = 1'b0;
        cyc_n(4);
        record_wait("zeros", 50, lat);
        chk("zeros_latency_window", 32'(lat >= 124 && lat <= 136), 32'd1);
        chk("zeros_count", 32'(sample_count_out), 32'd4);
        for (int a = 0; a < 4; a++) rd_chk("zeros_ram", a, 16'h0000);

        // Alternating bits per tick: half scale.
        alt_en = 1'b1;
        cyc_n(4);
        record_wait("alt", -1, lat);
        alt_en = 1'b0;
        for (int a = 0; a < 4; a++) rd_chk("alt_ram", a, 16'h8000);

        // Stop 40 cycles in: one sample kept, RAM[1] keeps its old value.
        mic_data_in = 1'b0;
        cyc_n(2);
        record_in = 1'b1;
        cyc_n(1);
        record_in = 1'b0;
        cyc_n(39);
        stop_in = 1'b1;
        cyc_n(1);
        stop_in = 1'b0;
        chk("stop_done", 32'(done_out), 32'd1);
        chk("stop_count", 32'(sample_count_out), 32'd1);
        rd_chk("stop_ram0", 0, 16'h0000);
        rd_chk("stop_ram1_unchanged", 1, 16'h8000);

        // Reset mid-record: busy drops, no done, count cleared.
        record_in = 1'b1;
        cyc_n(1);
        record_in = 1'b0;
        cyc_n(30);
        d0 = done_seen;
        rst_in = 1'b1;
        cyc_n(1);
        rst_in = 1'b0;
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_count", 32'(sample_count_out), 32'd0);
        cyc_n(5);
        chk("rst_no_done", 32'(done_seen - d0), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            mic_data_in = 1'($urandom);
            record_in   = ($urandom_range(0, 49) == 0);
            stop_in     = ($urandom_range(0, 399) == 0);
            rst_in      = ($urandom_range(0, 1499) == 0);
            rd_addr_in  = ADDR_W'($urandom);
            cyc_n(1);
        end
        rst_in    = 1'b0;
        stop_in   = 1'b0;
        record_in = 1'b0;
        cyc_n(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
